instr_mem_pipelined: RTL
========================

Name: instr_mem_pipelined

Overview:
- Parametrised, writable instruction memory for the datapath.
- Word-aligned fetch port with configurable registered read latency.
- Separate programming port lets the bench or a boot loader load the program at run time; a lock bit write-protects it afterwards.
- Misaligned and out-of-range fetches are flagged, never returned as X.

Parameters:
- ADDR_W, 64, fetch/program byte-address width.
- DATA_W, 32, instruction word width; power of two, at least 8.
- DEPTH, 64, number of instruction words; power of two, at least 2.
- RD_LAT, 1, fetch latency in cycles, legal values 1..3.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- FetchValid  in  1  fetch request this cycle.
- Address  in  ADDR_W  fetch byte address.
- DataValid  out  1  response valid, RD_LAT cycles after the request.
- Data  out  DATA_W  fetched instruction word.
- Fault  out  1  qualifies DataValid; request was misaligned or out of range.
- ProgValid  in  1  program-write request.
- ProgAddr  in  ADDR_W  program-write byte address.
- ProgData  in  DATA_W  program-write word.
- ProgReady  out  1  write port accepts; low while locked.
- ProgErr  out  1  one-cycle pulse on a rejected program write.
- Lock  in  1  pulse; sets the write-protect bit.
- Locked  out  1  write-protect status.

Behaviour:
- Constants: BYTES = DATA_W/8; OFF = log2(BYTES); IDX = log2(DEPTH).
- Word index = Address[OFF+IDX-1:OFF].
- Misaligned: Address[OFF-1:0] != 0.
- Out of range: any Address bit at or above OFF+IDX is set.
- Fetch pipeline:
  - RD_LAT stages, each holding {valid, fault, word}.
  - Stage 0 captures the array read on the edge when FetchValid=1.
  - Stage RD_LAT-1 drives the outputs: a request at edge n gives DataValid=1 after edge n+RD_LAT-1, visible in the cycle after edge n+RD_LAT-1.
  - Fully pipelined: one request per cycle, no stalls, no backpressure.
- Faulting fetch: DataValid=1, Fault=1, Data=0. The array is not read.
- Idle cycles: DataValid=0, Fault=0. Data holds its last value.
- Program write:
  - Accepted when ProgValid and ProgReady, on that edge.
  - Aligned and in range: the word is written.
  - Misaligned or out of range: no write, ProgErr pulses the next cycle.
- Write while locked: no write, ProgErr pulses.
- Simultaneous fetch and write to the same word in one cycle: read-first, so the fetch returns the old word. The new word is visible to fetches from the next cycle.
- Lock: sets Locked on the next edge. Only Reset clears it.
  - ProgReady = ~Locked.
  - Lock and ProgValid in the same cycle: the write is accepted (the lock takes effect after that edge).
- Reset:
  - Clears all pipeline valid/fault bits, Data, ProgErr and Locked.
  - Array contents are preserved.
  - Reset asserted mid-pipeline: in-flight fetches are discarded, with no DataValid for them.
  - Requests presented while Reset=1 are ignored.
- Array contents before any write are undefined. The bench must program every word it fetches.
- Synthesis: behavioural register array; no vendor macros.

Decomposition:
- Shared package:
  - FAULT_MISALIGN and FAULT_RANGE codes, for future fault-cause reporting.
  - Helper function computing OFF from DATA_W.
  - RD_LAT_MAX = 3.
- One sub-module, instr_mem_array: synchronous read-first single-write/single-read register array, parametrised on DEPTH and DATA_W.
- The top level holds address checks, the fetch pipeline, lock and ProgErr logic.

Test Plan:
- Load and fetch (RD_LAT=1):
  - Stimulus: program 0x000=F84003E9, 0x004=F84083EA, 0x008=F84103EB.
  - Stimulus: fetch 0x000, 0x004, 0x008 on consecutive cycles.
  - Required: DataValid on three consecutive cycles, Data = F84003E9, F84083EA, F84103EB, Fault=0.
- Latency sweep, RD_LAT=3:
  - Stimulus: program 0x010=8B0901AD, then fetch 0x010 once.
  - Required: DataValid=1 exactly 3 cycles after the request, Data=8B0901AD.
  - Required: back-to-back fetches stream one response per cycle.
- Faults:
  - Stimulus: fetch 0x002.
  - Required: Fault=1, Data=0.
  - Stimulus: fetch 0x100 with DEPTH=64.
  - Required: Fault=1.
  - Stimulus: program-write to 0x003.
  - Required: ProgErr pulses, and a later fetch of 0x000 still returns its prior value.
- Same-cycle write and fetch:
  - Stimulus: word 0x020 holds 0x11111111; write 0x22222222 and fetch 0x020 in the same cycle.
  - Required: that fetch returns 0x11111111; the next fetch returns 0x22222222.
- Lock:
  - Stimulus: pulse Lock.
  - Required: Locked=1 and ProgReady=0 from the next cycle.
  - Stimulus: write 0xDEADBEEF to 0x000.
  - Required: ProgErr=1 and the fetch still returns F84003E9.
  - Stimulus: Reset.
  - Required: Locked=0.
- Reset mid-flight:
  - Stimulus: with RD_LAT=2, fetch 0x004, then assert Reset the next cycle.
  - Required: no DataValid appears; DataValid=0, Data=0, ProgErr=0 after reset.
  - Required: word 0x004 still reads F84083EA after reset.

Source files
------------

// File: rtl/instr_mem_pipelined_pkg.sv
// Shared constants, fault-cause codes and sizing helpers for the instruction memory.
package instr_mem_pipelined_pkg;

    // Deepest fetch pipeline the top level is built to support.
    localparam int unsigned RD_LAT_MAX = 3;

    // Fault causes. Only their presence is reported today; the codes are kept
    // so a later revision can expose the cause without renumbering.
    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2
    } fault_e;

    // Number of byte-offset bits inside one instruction word.
    function automatic int unsigned word_off(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Synchronous register array: one write port, one registered read port, read-first.
// Ports:
//   clk, rst            clock, synchronous active-high clear of the read register
//   rd_en, rd_idx       load rd_data from word rd_idx on this edge
//   rd_clr              load zero into rd_data on this edge (takes precedence over rd_en)
//   rd_data             registered read word; holds while neither rd_en nor rd_clr
//   wr_en, wr_idx, wr_data  write port; storage itself is never reset
module instr_mem_array
    import instr_mem_pipelined_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned IDX   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [IDX-1:0]    rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX-1:0]    wr_idx,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read register samples the pre-write contents, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/instr_mem_pipelined.sv
// Writable instruction memory with a word-aligned fetch port of RD_LAT cycles latency,
// a program-write port and a sticky write-protect lock.
// Ports:
//   CLK, Reset                   clock, synchronous active-high reset
//   FetchValid, Address          fetch request and byte address
//   DataValid, Data, Fault       fetch response; Fault qualifies DataValid, Data=0 on fault
//   ProgValid, ProgAddr, ProgData  program-write request
//   ProgReady                    write port open (not locked)
//   ProgErr                      one-cycle pulse after a rejected program write
//   Lock, Locked                 set write-protect, write-protect status
module instr_mem_pipelined
    import instr_mem_pipelined_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              FetchValid,
    input  logic [ADDR_W-1:0] Address,
    output logic              DataValid,
    output logic [DATA_W-1:0] Data,
    output logic              Fault,
    input  logic              ProgValid,
    input  logic [ADDR_W-1:0] ProgAddr,
    input  logic [DATA_W-1:0] ProgData,
    output logic              ProgReady,
    output logic              ProgErr,
    input  logic              Lock,
    output logic              Locked
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF   = word_off(DATA_W);
    localparam int unsigned IDX   = $clog2(DEPTH);

    // Classify a byte address; range is checked first since it dominates.
    function automatic fault_e addr_cause(input logic [ADDR_W-1:0] a);
        if ((a >> (OFF + IDX)) != '0) begin
            return FAULT_RANGE;
        end
        if ((a & ADDR_W'(BYTES - 1)) != '0) begin
            return FAULT_MISALIGN;
        end
        return FAULT_NONE;
    endfunction

    fault_e            fetch_cause;
    fault_e            prog_cause;
    logic              fetch_bad;
    logic              prog_bad;
    logic              rd_en;
    logic              rd_clr;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;
    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] fault_q;
    logic              locked_q;
    logic              perr_q;

    // Address checks and array port control.
    always_comb begin
        fetch_cause = addr_cause(Address);
        prog_cause  = addr_cause(ProgAddr);
        fetch_bad   = (fetch_cause != FAULT_NONE);
        prog_bad    = (prog_cause != FAULT_NONE);
        rd_en       = FetchValid & ~fetch_bad & ~Reset;
        rd_clr      = FetchValid & fetch_bad;
        wr_en       = ProgValid & ~locked_q & ~prog_bad & ~Reset;
    end

    // Stage-0 word register lives in the array's read port.
    instr_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (CLK),
        .rst     (Reset),
        .rd_en   (rd_en),
        .rd_clr  (rd_clr),
        .rd_idx  (Address[OFF+IDX-1:OFF]),
        .rd_data (rd_word),
        .wr_en   (wr_en),
        .wr_idx  (ProgAddr[OFF+IDX-1:OFF]),
        .wr_data (ProgData)
    );

    // Valid/fault shift chain; the cast drops the bit shifted out of the top stage.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            valid_q <= '0;
            fault_q <= '0;
        end else begin
            valid_q <= RD_LAT'({valid_q, FetchValid});
            fault_q <= RD_LAT'({fault_q, FetchValid & fetch_bad});
        end
    end

    // Later word stages advance only behind a valid beat, so Data holds across idle cycles.
    if (RD_LAT == 1) begin : g_direct
        assign Data = rd_word;
    end else begin : g_tail
        logic [DATA_W-1:0] tail_q [RD_LAT-1];

        always_ff @(posedge CLK) begin
            if (Reset) begin
                for (int k = 0; k < int'(RD_LAT) - 1; k++) begin
                    tail_q[k] <= '0;
                end
            end else begin
                if (valid_q[0]) begin
                    tail_q[0] <= rd_word;
                end
                for (int k = 1; k < int'(RD_LAT) - 1; k++) begin
                    if (valid_q[k]) begin
                        tail_q[k] <= tail_q[k-1];
                    end
                end
            end
        end

        assign Data = tail_q[RD_LAT-2];
    end

    // Lock is sticky until reset; any write refused this edge pulses ProgErr next cycle.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            locked_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            locked_q <= locked_q | Lock;
            perr_q   <= ProgValid & (locked_q | prog_bad);
        end
    end

    assign DataValid = valid_q[RD_LAT-1];
    assign Fault     = fault_q[RD_LAT-1];
    assign Locked    = locked_q;
    assign ProgReady = ~locked_q;
    assign ProgErr   = perr_q;

endmodule
